// File: rtl/proc_run_controller.sv
// Run controller for the singlecycle processor: holds it in reset, loads the start PC,
// runs until the PC reaches an end address or the watchdog fires, then samples the result.
module proc_run_controller #(
  parameter int PC_WIDTH       = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int RESET_CYCLES   = 1,
  parameter int WATCHDOG_LIMIT = 255
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   start_pc,
  input  logic [PC_WIDTH-1:0]   end_pc,
  input  logic [DATA_WIDTH-1:0] expected,
  output logic                  proc_resetl,
  output logic [PC_WIDTH-1:0]   proc_startpc,
  input  logic [PC_WIDTH-1:0]   proc_currentpc,
  input  logic [DATA_WIDTH-1:0] proc_dmemout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [DATA_WIDTH-1:0] actual,
  output logic [15:0]           cycle_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RESET = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int RCW = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);

  logic [2:0]            state;
  logic [RCW-1:0]        hold_cnt;
  logic [PC_WIDTH-1:0]   end_pc_lat;
  logic [DATA_WIDTH-1:0] expected_lat;
  logic [15:0]           cnt_inc;
  logic [31:0]           cnt_next32;

  // Processor only runs while we are watching it; everywhere else it is frozen in reset.
  assign proc_resetl = (state == S_RUN) || (state == S_DRAIN);
  assign busy        = (state == S_RESET) || (state == S_RUN) || (state == S_DRAIN);
  assign cnt_inc     = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
  assign cnt_next32  = {16'd0, cycle_count} + 32'd1;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      hold_cnt     <= '0;
      proc_startpc <= '0;
      end_pc_lat   <= '0;
      expected_lat <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      actual       <= '0;
      cycle_count  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            proc_startpc <= start_pc;
            end_pc_lat   <= end_pc;
            expected_lat <= expected;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
            hold_cnt     <= RCW'(RESET_CYCLES);
            state        <= S_RESET;
          end
        end
        S_RESET: begin
          hold_cnt <= hold_cnt - RCW'(1);
          if (hold_cnt <= RCW'(1)) state <= S_RUN;
        end
        S_RUN: begin
          cycle_count <= cnt_inc;
          // PC reaching the end takes priority over a watchdog hit in the same cycle.
          if (proc_currentpc >= end_pc_lat) begin
            state <= S_DRAIN;
          end else if (cnt_next32 == 32'(WATCHDOG_LIMIT)) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DRAIN: begin
          cycle_count <= cnt_inc;
          actual      <= proc_dmemout;
          pass        <= (proc_dmemout == expected_lat);
          timeout     <= 1'b0;
          done        <= 1'b1;
          state       <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_run_controller.sv
// Scoreboard bench for proc_run_controller with a behavioural processor model (PC +4 or stuck).
module tb_proc_run_controller;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start, start3;
  logic [63:0] start_pc, end_pc, expected;
  logic        proc_resetl, proc_resetl3;
  logic [63:0] proc_startpc, proc_startpc3;
  logic [63:0] pc, pc3, dmem, dmem3;
  logic        busy, done, pass, timeout;
  logic        busy3, done3, pass3, timeout3;
  logic [63:0] actual, actual3;
  logic [15:0] cycle_count, cycle_count3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        pass;
    logic        timeout;
    logic [63:0] actual;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  // processor model knobs
  bit          stuck;
  logic [63:0] code;
  logic [63:0] model_end;
  logic [63:0] last_actual;
  logic        done_q;

  always #5 CLK = ~CLK;

  proc_run_controller dut (
    .CLK(CLK), .reset(reset), .start(start), .start_pc(start_pc), .end_pc(end_pc),
    .expected(expected), .proc_resetl(proc_resetl), .proc_startpc(proc_startpc),
    .proc_currentpc(pc), .proc_dmemout(dmem), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .actual(actual), .cycle_count(cycle_count)
  );

  proc_run_controller #(.RESET_CYCLES(3)) dut3 (
    .CLK(CLK), .reset(reset), .start(start3), .start_pc(64'h100), .end_pc(64'h0),
    .expected(64'h77), .proc_resetl(proc_resetl3), .proc_startpc(proc_startpc3),
    .proc_currentpc(pc3), .proc_dmemout(dmem3), .busy(busy3), .done(done3), .pass(pass3),
    .timeout(timeout3), .actual(actual3), .cycle_count(cycle_count3)
  );

  always @(posedge CLK) begin
    if (!proc_resetl) pc <= proc_startpc;
    else if (!stuck)  pc <= pc + 64'd4;
    if (!proc_resetl3) pc3 <= proc_startpc3;
    else               pc3 <= pc3 + 64'd4;
  end
  assign dmem  = (pc >= model_end) ? code : 64'h0;
  assign dmem3 = 64'h77;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Compare against the scoreboard whenever done rises.
  always @(negedge CLK) begin
    if (done && !done_q) begin
      if (sb.size() == 0) check("sb_empty", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("pass",        {63'd0, pass},    {63'd0, e.pass});
        check("timeout",     {63'd0, timeout}, {63'd0, e.timeout});
        check("actual",      actual,           e.actual);
        check("cycle_count", {48'd0, cycle_count}, {48'd0, e.cnt});
      end
    end
    done_q <= done;
  end

  task automatic start_run(input logic [63:0] spc, input logic [63:0] epc,
                           input logic [63:0] expv, input bit stk, input logic [63:0] cd);
    exp_t e;
    int   n;
    logic [63:0] p;
    stuck = stk; code = cd; model_end = epc;
    n = 1; p = spc;
    while (!stk && p < epc && n < 255) begin p += 64'd4; n++; end
    if (stk && spc < epc) begin
      e.pass = 1'b0; e.timeout = 1'b1; e.actual = last_actual; e.cnt = 16'd255;
    end else begin
      e.pass = (cd == expv); e.timeout = 1'b0; e.actual = cd; e.cnt = 16'(n + 1);
      last_actual = cd;
    end
    sb.push_back(e);
    @(negedge CLK);
    start_pc = spc; end_pc = epc; expected = expv; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 2000 && !done; k++) @(negedge CLK);
    if (!done) check({tag, "_wait"}, 64'd0, 64'd1);
    @(negedge CLK);
  endtask

  task automatic wait_done3(input string tag);
    int k;
    for (k = 0; k < 200 && !done3; k++) @(negedge CLK);
    if (!done3) check({tag, "_wait"}, 64'd0, 64'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; start3 = 1'b0; stuck = 1'b0; code = '0; model_end = '0;
    start_pc = '0; end_pc = '0; expected = '0; last_actual = '0; done_q = 1'b0;
    #1;
    check("rst_resetl", {63'd0, proc_resetl}, 64'd0);
    check("rst_busy",   {63'd0, busy},        64'd0);
    check("rst_done",   {63'd0, done},        64'd0);
    check("rst_actual", actual,               64'd0);
    check("rst_cnt",    {48'd0, cycle_count}, 64'd0);
    check("rst_spc",    proc_startpc,         64'd0);
    repeat (2) @(negedge CLK);
    reset = 1'b0;

    // 1: normal pass; processor held in reset for one cycle
    start_run(64'h0, 64'h34, 64'hF, 1'b0, 64'hF);
    check("s1_hold", {62'd0, busy, proc_resetl}, 64'b10);
    @(negedge CLK);
    check("s1_run", {62'd0, busy, proc_resetl}, 64'b11);
    wait_done("s1");

    // 2: wrong result code
    start_run(64'h0, 64'h34, 64'hF, 1'b0, 64'hE);
    wait_done("s2");

    // 3: PC stuck, watchdog fires
    start_run(64'h10, 64'h34, 64'hF, 1'b1, 64'hF);
    wait_done("s3");
    check("s3_resetl", {63'd0, proc_resetl}, 64'd0);

    // 4: reset in the fifth RUN cycle
    start_run(64'h0, 64'h34, 64'hF, 1'b0, 64'hF);
    repeat (5) @(negedge CLK);
    reset = 1'b1;
    #1;
    check("s4_busy",   {63'd0, busy},        64'd0);
    check("s4_done",   {63'd0, done},        64'd0);
    check("s4_resetl", {63'd0, proc_resetl}, 64'd0);
    check("s4_cnt",    {48'd0, cycle_count}, 64'd0);
    sb.delete();
    last_actual = 64'h0;
    @(negedge CLK);
    reset = 1'b0;
    start_run(64'h0, 64'h34, 64'hF, 1'b0, 64'hF);
    wait_done("s4b");

    // 5: start during RUN is ignored, original expected is kept
    start_run(64'h0, 64'h34, 64'hF, 1'b0, 64'hF);
    repeat (3) @(negedge CLK);
    expected = 64'h1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("s5_busy", {63'd0, busy}, 64'd1);
    check("s5_done", {63'd0, done}, 64'd0);
    wait_done("s5");

    // 6: RESET_CYCLES=3, end_pc=0
    @(negedge CLK);
    start3 = 1'b1;
    @(negedge CLK);
    start3 = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && !proc_resetl3; k++) begin
      if (busy3) n++;
      @(negedge CLK);
    end
    check("s6_hold", 64'(n), 64'd3);
    wait_done3("s6");
    check("s6_cnt",  {48'd0, cycle_count3}, 64'd2);
    check("s6_pass", {63'd0, pass3},        64'd1);
    check("s6_to",   {63'd0, timeout3},     64'd0);
    start3 = 1'b1;
    @(negedge CLK);
    start3 = 1'b0;
    check("s6b_done", {63'd0, done3}, 64'd0);
    check("s6b_busy", {63'd0, busy3}, 64'd1);
    wait_done3("s6b");
    check("s6b_pass", {63'd0, pass3},        64'd1);
    check("s6b_cnt",  {48'd0, cycle_count3}, 64'd2);

    check("sb_left", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
